// File: rtl/key_ctrl.sv
// -----------------------------------------------------------------------------
// key_ctrl
//
// Push-button front end for the neural-engine core. Up to four active-low board
// keys are synchronised and debounced; key 0 acts as a manual reset button and
// key 1 (when present) toggles pause/resume. A small sequencer turns those key
// states into the system reset and start indications and drives status LEDs.
//
// Parameters
//   N_KEYS          number of keys (1..4); pause exists only for N_KEYS >= 2
//   DEBOUNCE_CYCLES stable cycles on the synchronised input to accept a change
//   RESET_STRETCH   cycles reset_signal is held after key 0 / rst_n release
//   START_PULSE     0: start_signal is a level while running
//                   1: start_signal is a single-cycle strobe per START entry
//   N_LEDS          LED bus width, >= 3 + N_KEYS
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   KEY           raw keys, active-low, asynchronous to clk
//   reset_signal  active-high reset for downstream logic
//   start_signal  start indication (level or strobe, see START_PULSE)
//   key_pressed   debounced key levels, 1 = held
//   key_event     one-cycle strobe in the cycle after key_pressed rises
//   LED           {0.., key_pressed, paused, running, reset_signal}
//
// Every output comes straight from a flop, so nothing on KEY can glitch an
// output combinationally.
// -----------------------------------------------------------------------------
module key_ctrl #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RESET_STRETCH   = 16,
  parameter int START_PULSE     = 0,
  parameter int N_LEDS          = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] KEY,
  output logic              reset_signal,
  output logic              start_signal,
  output logic [N_KEYS-1:0] key_pressed,
  output logic [N_KEYS-1:0] key_event,
  output logic [N_LEDS-1:0] LED
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH) : 1;

  // Elaboration-time sanity checks on the parameter set.
  if (N_KEYS < 1 || N_KEYS > 4) begin : g_bad_nkeys
    $error("key_ctrl: N_KEYS must be 1..4");
  end
  if (N_LEDS < 3 + N_KEYS) begin : g_bad_nleds
    $error("key_ctrl: N_LEDS must be >= 3 + N_KEYS");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("key_ctrl: DEBOUNCE_CYCLES must be >= 2");
  end
  if (RESET_STRETCH < 1) begin : g_bad_rs
    $error("key_ctrl: RESET_STRETCH must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Per-key synchroniser, debouncer and press-event generator
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pressed_q;
    logic          pressed_d;
    logic          pressed_dly_q;
    logic          event_q;

    // The synchronised pin is active-low; compare its inverted value against
    // the accepted level. Any cycle where they agree throws the count away,
    // so a single bounce restarts the full debounce window.
    always_comb begin
      cnt_d     = '0;
      pressed_d = pressed_q;
      if ((~sync2_q) != pressed_q) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
          pressed_d = ~pressed_q;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q       <= 1'b1;  // released
        sync2_q       <= 1'b1;
        cnt_q         <= '0;
        pressed_q     <= 1'b0;
        pressed_dly_q <= 1'b0;
        event_q       <= 1'b0;
      end else begin
        sync1_q       <= KEY[gi];
        sync2_q       <= sync1_q;
        cnt_q         <= cnt_d;
        pressed_q     <= pressed_d;
        pressed_dly_q <= pressed_q;
        // Strobe lands in the cycle after the accepted level rises.
        event_q       <= pressed_q & ~pressed_dly_q;
      end
    end

    assign key_pressed[gi] = pressed_q;
    assign key_event[gi]   = event_q;
  end

  // Pause toggle source; tied off when there is no second key.
  logic pause_evt;
  if (N_KEYS >= 2) begin : g_pause
    assign pause_evt = key_event[1];
  end else begin : g_no_pause
    assign pause_evt = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Reset / start / pause sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    ST_RST_HOLD,
    ST_RST_STRETCH,
    ST_START,
    ST_RUN,
    ST_PAUSE
  } state_e;

  state_e        state_q;
  state_e        state_d;
  logic [SW-1:0] stretch_q;
  logic [SW-1:0] stretch_d;
  logic          reset_q;
  logic          start_q;
  logic          run_led_q;
  logic          pause_led_q;

  // Key 0 is checked before the key-1 event everywhere, so a simultaneous
  // press always lands in RST_HOLD. Key-1 events seen outside RUN/PAUSE fall
  // through the case and are simply lost.
  always_comb begin
    state_d   = state_q;
    stretch_d = stretch_q;
    case (state_q)
      ST_RST_HOLD: begin
        if (!key_pressed[0]) begin
          state_d   = ST_RST_STRETCH;
          stretch_d = '0;
        end
      end
      ST_RST_STRETCH: begin
        if (key_pressed[0]) begin
          state_d = ST_RST_HOLD;
        end else if (stretch_q == SW'(RESET_STRETCH - 1)) begin
          state_d = ST_START;
        end else begin
          stretch_d = stretch_q + SW'(1);
        end
      end
      ST_START: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (key_pressed[0]) begin
          state_d = ST_RST_HOLD;
        end else if (pause_evt) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (key_pressed[0]) begin
          state_d = ST_RST_HOLD;
        end else if (pause_evt) begin
          state_d = ST_START;  // resume re-issues the start strobe
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
      end
    endcase
  end

  // Outputs are decoded from the next state so that each one reflects the
  // state entered on the same edge while still coming from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RST_STRETCH;
      stretch_q   <= '0;
      reset_q     <= 1'b1;
      start_q     <= 1'b0;
      run_led_q   <= 1'b0;
      pause_led_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stretch_q   <= stretch_d;
      reset_q     <= (state_d == ST_RST_HOLD) || (state_d == ST_RST_STRETCH);
      start_q     <= (state_d == ST_START) ||
                     ((state_d == ST_RUN) && (START_PULSE == 0));
      run_led_q   <= (state_d == ST_RUN);
      pause_led_q <= (state_d == ST_PAUSE);
    end
  end

  assign reset_signal = reset_q;
  assign start_signal = start_q;

  always_comb begin
    LED               = '0;
    LED[0]            = reset_q;
    LED[1]            = run_led_q;
    LED[2]            = pause_led_q;
    LED[3 +: N_KEYS]  = key_pressed;
  end

endmodule

// File: tb/tb_key_ctrl.sv
// -----------------------------------------------------------------------------
// tb_key_ctrl
//
// Directed bench for key_ctrl with DEBOUNCE_CYCLES=4, RESET_STRETCH=3,
// N_KEYS=2, N_LEDS=10. Two instances share clock, reset and keys: u_lvl runs
// with START_PULSE=0 and u_pls with START_PULSE=1.
//
// Timing reference used in the expected values below: inputs change 1 ns after
// a rising edge (call that edge 0). The pin is then captured on edges 1 and 2,
// the debounce counter counts on edges 3..5 and key_pressed flips on edge 6.
// key_event follows on edge 7, the sequencer reacts to key_event on edge 8 and
// to key_pressed[0] on edge 7.
// -----------------------------------------------------------------------------
module tb_key_ctrl;
  localparam int NK = 2;
  localparam int DB = 4;
  localparam int RS = 3;
  localparam int NL = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key;

  logic          rs_l, ss_l, rs_p, ss_p;
  logic [NK-1:0] kp_l, ke_l, kp_p, ke_p;
  logic [NL-1:0] led_l, led_p;

  int vectors     = 0;
  int miscompares = 0;
  int pulses;

  always #5 clk = ~clk;

  key_ctrl #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RESET_STRETCH(RS),
    .START_PULSE(0), .N_LEDS(NL)
  ) u_lvl (
    .clk(clk), .rst_n(rst_n), .KEY(key),
    .reset_signal(rs_l), .start_signal(ss_l),
    .key_pressed(kp_l), .key_event(ke_l), .LED(led_l)
  );

  key_ctrl #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(DB), .RESET_STRETCH(RS),
    .START_PULSE(1), .N_LEDS(NL)
  ) u_pls (
    .clk(clk), .rst_n(rst_n), .KEY(key),
    .reset_signal(rs_p), .start_signal(ss_p),
    .key_pressed(kp_p), .key_event(ke_p), .LED(led_p)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("[%0t] vec %0d %s obs=0x%0h", $time, vectors, tag, obs);
  endtask

  initial begin
    // ---------------- power-up ----------------
    rst_n = 1'b1;
    key   = 2'b11;
    #2 rst_n = 1'b0;
    tick(5);
    chk("por_reset", 32'(rs_l), 32'd1);
    chk("por_led", 32'(led_l), 32'h001);
    chk("por_kp", 32'(kp_l), 32'd0);
    chk("por_ke", 32'(ke_l), 32'd0);
    chk("por_start_l", 32'(ss_l), 32'd0);
    chk("por_start_p", 32'(ss_p), 32'd0);
    rst_n = 1'b1;                        // just after edge 1
    tick(1);                             // edge 2
    chk("por_e2_reset", 32'(rs_l), 32'd1);
    chk("por_e2_start", 32'(ss_l), 32'd0);
    tick(1);                             // edge 3
    chk("por_e3_reset", 32'(rs_l), 32'd1);
    tick(1);                             // edge 4: START
    chk("por_e4_reset", 32'(rs_l), 32'd0);
    chk("por_e4_start_l", 32'(ss_l), 32'd1);
    chk("por_e4_start_p", 32'(ss_p), 32'd1);
    chk("por_e4_led", 32'(led_l), 32'h000);
    tick(1);                             // edge 5: RUN
    chk("por_e5_led", 32'(led_l), 32'h002);
    chk("por_e5_start_l", 32'(ss_l), 32'd1);
    chk("por_e5_start_p", 32'(ss_p), 32'd0);

    // ---------------- bounce reject ----------------
    // low 3, high 1, low 3, then high: the count never reaches 4.
    for (int i = 0; i < 15; i++) begin
      if (i == 0 || i == 4) key = 2'b10;
      if (i == 3 || i == 7) key = 2'b11;
      tick(1);
      chk("bounce_kp", 32'(kp_l), 32'd0);
      chk("bounce_led", 32'(led_l), 32'h002);
    end

    // ---------------- manual reset ----------------
    key = 2'b10;
    tick(5);
    chk("man_kp_e5", 32'(kp_l), 32'd0);
    tick(1);
    chk("man_kp_e6", 32'(kp_l), 32'd1);
    chk("man_reset_e6", 32'(rs_l), 32'd0);
    chk("man_led_e6", 32'(led_l), 32'h00A);
    tick(1);
    chk("man_reset_e7", 32'(rs_l), 32'd1);
    chk("man_led_e7", 32'(led_l), 32'h009);
    chk("man_ke_e7", 32'(ke_l), 32'd1);
    chk("man_start_e7", 32'(ss_l), 32'd0);
    tick(1);
    chk("man_ke_e8", 32'(ke_l), 32'd0);
    tick(12);                            // edge 20, still held
    chk("man_hold_led", 32'(led_l), 32'h009);
    key = 2'b11;
    tick(5);
    chk("rel_kp_e5", 32'(kp_l), 32'd1);
    tick(1);
    chk("rel_kp_e6", 32'(kp_l), 32'd0);
    chk("rel_reset_e6", 32'(rs_l), 32'd1);
    for (int i = 7; i <= 9; i++) begin   // three RST_STRETCH cycles
      tick(1);
      chk("rel_stretch_reset", 32'(rs_l), 32'd1);
      chk("rel_stretch_led", 32'(led_l), 32'h001);
    end
    tick(1);                             // edge 10: START
    chk("rel_start_reset", 32'(rs_l), 32'd0);
    chk("rel_start_l", 32'(ss_l), 32'd1);
    chk("rel_start_p", 32'(ss_p), 32'd1);
    chk("rel_start_led", 32'(led_l), 32'h000);
    tick(1);                             // edge 11: RUN
    chk("rel_run_led", 32'(led_l), 32'h002);
    chk("rel_run_start_p", 32'(ss_p), 32'd0);

    // ---------------- pause / resume ----------------
    key = 2'b01;
    tick(5);
    chk("p1_kp_e5", 32'(kp_l), 32'd0);
    tick(1);
    chk("p1_kp_e6", 32'(kp_l), 32'd2);
    chk("p1_ke_e6", 32'(ke_l), 32'd0);
    chk("p1_led_e6", 32'(led_l), 32'h012);
    tick(1);
    chk("p1_ke_e7", 32'(ke_l), 32'd2);
    chk("p1_led_e7", 32'(led_l), 32'h012);
    tick(1);                             // edge 8: PAUSE
    chk("p1_ke_e8", 32'(ke_l), 32'd0);
    chk("p1_led_e8", 32'(led_l), 32'h014);
    chk("p1_start_l", 32'(ss_l), 32'd0);
    chk("p1_start_p", 32'(ss_p), 32'd0);
    tick(2);
    key = 2'b11;                         // release at edge 10
    tick(6);                             // edge 16: released, no event
    chk("p1_rel_kp", 32'(kp_l), 32'd0);
    chk("p1_rel_led", 32'(led_l), 32'h004);
    tick(1);
    chk("p1_rel_ke", 32'(ke_l), 32'd0);
    tick(13);                            // edge 30
    chk("p1_idle_led", 32'(led_l), 32'h004);
    key = 2'b01;                         // second press
    tick(6);
    chk("p2_kp_e6", 32'(kp_l), 32'd2);
    chk("p2_led_e6", 32'(led_l), 32'h014);
    tick(1);
    chk("p2_ke_e7", 32'(ke_l), 32'd2);
    tick(1);                             // edge 8: START
    chk("p2_start_l", 32'(ss_l), 32'd1);
    chk("p2_start_p", 32'(ss_p), 32'd1);
    chk("p2_led_e8", 32'(led_l), 32'h010);
    tick(1);                             // edge 9: RUN
    chk("p2_led_e9", 32'(led_l), 32'h012);
    chk("p2_start_l_e9", 32'(ss_l), 32'd1);
    chk("p2_start_p_e9", 32'(ss_p), 32'd0);
    tick(1);
    key = 2'b11;
    tick(6);
    chk("p2_rel_led", 32'(led_l), 32'h002);

    // ---------------- simultaneous keys ----------------
    key = 2'b00;
    tick(6);
    chk("sim_kp_e6", 32'(kp_l), 32'd3);
    chk("sim_led_e6", 32'(led_l), 32'h01A);
    tick(1);
    chk("sim_reset_e7", 32'(rs_l), 32'd1);
    chk("sim_ke_e7", 32'(ke_l), 32'd3);
    chk("sim_led_e7", 32'(led_l), 32'h019);
    for (int i = 8; i <= 15; i++) begin
      tick(1);
      chk("sim_hold_led", 32'(led_l), 32'h019);
    end
    key = 2'b11;                         // release at edge 15
    pulses = 0;
    for (int i = 16; i <= 30; i++) begin
      tick(1);
      if (ss_p) pulses++;
      chk("sim_no_pause", 32'(led_l[2]), 32'd0);
      if (i == 25) chk("sim_start_e25", 32'(ss_p), 32'd1);
      if (i == 26) chk("sim_run_e26", 32'(led_l), 32'h002);
    end
    chk("sim_pulse_count", 32'(pulses), 32'd1);

    // ---------------- pulse mode with async rst_n mid-RUN ----------------
    key = 2'b01;
    tick(6);
    chk("arst_kp_before", 32'(kp_p), 32'd2);
    chk("arst_led_before", 32'(led_p), 32'h012);
    #2 rst_n = 1'b0;                     // between clock edges
    #1;
    chk("arst_reset_p", 32'(rs_p), 32'd1);
    chk("arst_kp_p", 32'(kp_p), 32'd0);
    chk("arst_ke_p", 32'(ke_p), 32'd0);
    chk("arst_start_p", 32'(ss_p), 32'd0);
    chk("arst_led_p", 32'(led_p), 32'h001);
    chk("arst_reset_l", 32'(rs_l), 32'd1);
    key = 2'b11;
    tick(2);
    rst_n = 1'b1;                        // just after edge 1
    pulses = 0;
    for (int i = 2; i <= 12; i++) begin
      tick(1);
      if (ss_p) pulses++;
      if (i == 3) chk("arst_e3_start_p", 32'(ss_p), 32'd0);
      if (i == 4) chk("arst_e4_start_p", 32'(ss_p), 32'd1);
      if (i == 5) chk("arst_e5_start_p", 32'(ss_p), 32'd0);
      if (i == 5) chk("arst_e5_led_p", 32'(led_p), 32'h002);
    end
    chk("arst_pulse_count", 32'(pulses), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
